pipe_controller: RTL
====================

PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALU control width; 3 gives the base op set, 4 adds sltu/xor/shifts.
REQ-002 Parameter BRANCH_EXT, default 1: 1 decodes beq/bne/blt/bge/bltu/bgeu; 0 decodes beq only, and other branches are illegal.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 opD  in  7  opcode of the instruction in Decode.
REQ-007 funct3D  in  3  funct3 in Decode.
REQ-008 funct7b5D  in  1  instr[30] in Decode.
REQ-009 StallE  in  1  hold the E, M and W control registers.
REQ-010 FlushE  in  1  load a bubble into the E register.
REQ-011 ZeroE, LtE, LtuE  in  1 each  ALU flags in Execute: equal, signed less-than, unsigned less-than.
REQ-012 ImmSrcD  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-013 IllegalD  out  1  opcode/funct3 in Decode is unsupported.
REQ-014 ALUSrcE  out  1  ALU B operand: 1 selects the immediate.
REQ-015 ALUControlE  out  ALUCTRL_W  ALU operation in Execute.
REQ-016 PCSrcE  out  1  redirect the PC (taken branch or jal).
REQ-017 ResultSrcE0  out  1  ResultSrcE[0], used by the hazard unit for load-use detection.
REQ-018 MemWriteM  out  1  data-memory write in Memory.
REQ-019 RegWriteM, RegWriteW  out  1 each  register-file write enable per stage, used for forwarding and writeback.
REQ-020 ResultSrcW  out  2  writeback select: 00 ALU, 01 memory, 10 PC+4.

Function
REQ-021 Decode is combinational from opD, funct3D and funct7b5D, and covers lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, branch 1100011 and jal 1101111.
REQ-022 Unsupported opcodes or branch funct3 values assert IllegalD and decode all write/branch/jump controls to 0 (bubble).
REQ-023 ALU codes: add 000, sub 001, and 010, or 011, slt 101; when ALUCTRL_W=4, the base codes are zero-extended and the extensions are sltu 0110, xor 0111, sll 1000, srl 1001, sra 1010.
REQ-024 Subtraction is decoded only for R-type with funct7b5D=1; srai/sra is decoded on funct7b5D=1.
REQ-025 Branches decode to sub; when ALUCTRL_W=4, bltu/bgeu decode to sltu.
REQ-026 Control register D->E holds RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl and funct3; the E->M and M->W registers carry the remaining stage controls; latency is 1 cycle per stage.
REQ-027 PCSrcE = JumpE | (BranchE & taken), combinational in E.
REQ-028 The taken condition by funct3E: 000 ZeroE, 001 !ZeroE, 100 LtE, 101 !LtE, 110 LtuE, 111 !LtuE.
REQ-029 Priority: reset > FlushE > StallE > normal load.
REQ-030 FlushE with StallE loads a bubble into E, and M and W hold.
REQ-031 A bubble forces RegWrite, MemWrite, Jump and Branch to 0, and all other fields to 0.
REQ-032 StallE holds E, M and W unchanged, so PCSrcE remains a function of the held E register and the current flags.

Reset
REQ-033 On reset, every E, M and W register field is 0 on the next edge, so RegWriteM=RegWriteW=MemWriteM=PCSrcE=0 and ResultSrcW=00.
REQ-034 Reset asserted mid-operation discards all in-flight controls within one cycle.
REQ-035 The combinational D outputs follow their inputs during reset.

Structure
REQ-036 Shared package riscv_ctrl_pkg holds the opcode constants, ALU control codes, ResultSrc/ImmSrc codes and the bubble value.
REQ-037 Sub-module ctrl_decode (combinational main plus ALU decode, parametrised by ALUCTRL_W and BRANCH_EXT) is instantiated once.
REQ-038 Pipeline registers live in pipe_controller.

Verification
REQ-039 lw x1 in D, then 3 clean cycles -> ResultSrcE0=1 at E, MemWriteM=0, RegWriteW=1 with ResultSrcW=01 at W.
REQ-040 bne in D, then ZeroE=0 in E -> PCSrcE=1; ZeroE=1 -> PCSrcE=0; with BRANCH_EXT=0, bne -> IllegalD=1 and PCSrcE=0.
REQ-041 sw in D with FlushE=1 and StallE=1 on the same edge -> E holds a bubble, MemWriteM=0 one cycle later, M/W unchanged.
REQ-042 R-type sub (funct7b5D=1), then StallE=1 for 2 cycles -> ALUControlE=001 held for 3 cycles, RegWriteM asserts one cycle after the stall is released.
REQ-043 Reset asserted while jal is in E and add is in M -> next edge PCSrcE=0, RegWriteM=0, RegWriteW=0.
REQ-044 ALUCTRL_W=4 with sra, sltu and xor -> ALUControlE = 1010, 0110 and 0111 respectively.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared constants and types for the pipelined RISC-V control
//                path. Holds the opcode constants, ALU control codes, ResultSrc
//                and ImmSrc codes, the per-stage control bundle, the bubble
//                value and the branch-condition helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Opcodes of the supported instruction classes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_ialu   = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // ALU control codes at the widest supported width (4 bits). The base set
    // fits in 3 bits, so a 3-bit ALU simply takes the low bits.
    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_slt  = 4'b0101;
    localparam logic [3:0] c_alu_sltu = 4'b0110;
    localparam logic [3:0] c_alu_xor  = 4'b0111;
    localparam logic [3:0] c_alu_sll  = 4'b1000;
    localparam logic [3:0] c_alu_srl  = 4'b1001;
    localparam logic [3:0] c_alu_sra  = 4'b1010;

    // Writeback select
    localparam logic [1:0] c_res_alu = 2'b00;
    localparam logic [1:0] c_res_mem = 2'b01;
    localparam logic [1:0] c_res_pc4 = 2'b10;

    // Immediate formats
    localparam logic [1:0] c_imm_i = 2'b00;
    localparam logic [1:0] c_imm_s = 2'b01;
    localparam logic [1:0] c_imm_b = 2'b10;
    localparam logic [1:0] c_imm_j = 2'b11;

    // Branch funct3 encodings
    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

    // Control fields carried from Decode into Execute (ALU control is kept
    // separately because its width is a parameter of the design).
    typedef struct packed {
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       memwrite;
        logic       jump;
        logic       branch;
        logic       alusrc;
        logic [2:0] funct3;
    } ctrl_t;

    // A bubble is the all-zero bundle: no write, no branch, no jump.
    localparam ctrl_t c_ctrl_bubble = '0;

    // Branch condition evaluated in Execute from the ALU flags.
    function automatic logic branch_taken(
        input logic [2:0] funct3,
        input logic       zero,
        input logic       lt,
        input logic       ltu
    );
        logic w_taken;
        case (funct3)
            c_f3_beq:  w_taken = zero;
            c_f3_bne:  w_taken = ~zero;
            c_f3_blt:  w_taken = lt;
            c_f3_bge:  w_taken = ~lt;
            c_f3_bltu: w_taken = ltu;
            c_f3_bgeu: w_taken = ~ltu;
            default:   w_taken = 1'b0;
        endcase
        return w_taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational main decoder and ALU decoder for the Decode
//                stage. Unsupported opcodes / branch funct3 values raise
//                IllegalD and decode to a bubble.
//  Parameters  : ALUCTRL_W  - ALU control width (3 base ops, 4 adds
//                             sltu/xor/shifts)
//                BRANCH_EXT - 1: full branch set, 0: beq only
//  Ports       : opD, funct3D, funct7b5D  in   instruction fields in Decode
//                ctrlD                    out  control bundle for Execute
//                ALUControlD              out  ALU operation
//                ImmSrcD                  out  immediate format
//                IllegalD                 out  unsupported instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter bit BRANCH_EXT = 1'b1
) (
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    output ctrl_t                ctrlD,
    output logic [ALUCTRL_W-1:0] ALUControlD,
    output logic [1:0]           ImmSrcD,
    output logic                 IllegalD
);

    localparam bit c_ext_alu = (ALUCTRL_W >= 4);

    ctrl_t w_ctrl;
    logic  w_illegal;
    logic  w_branch_ok;

    // Branch funct3 010/011 are never valid; without the extension only beq is.
    always_comb begin
        if (BRANCH_EXT) begin
            w_branch_ok = (funct3D != 3'b010) && (funct3D != 3'b011);
        end else begin
            w_branch_ok = (funct3D == c_f3_beq);
        end
    end

    // Main decoder
    always_comb begin
        w_ctrl    = c_ctrl_bubble;
        ImmSrcD   = c_imm_i;
        w_illegal = 1'b0;
        case (opD)
            c_op_load: begin
                w_ctrl.regwrite  = 1'b1;
                w_ctrl.resultsrc = c_res_mem;
                w_ctrl.alusrc    = 1'b1;
            end
            c_op_store: begin
                w_ctrl.memwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
                ImmSrcD         = c_imm_s;
            end
            c_op_rtype: begin
                w_ctrl.regwrite = 1'b1;
            end
            c_op_ialu: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 1'b1;
            end
            c_op_branch: begin
                ImmSrcD = c_imm_b;
                if (w_branch_ok) begin
                    w_ctrl.branch = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_op_jal: begin
                w_ctrl.regwrite  = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.resultsrc = c_res_pc4;
                ImmSrcD          = c_imm_j;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        // funct3 only travels with a legal instruction so a bubble stays all-zero
        if (!w_illegal) begin
            w_ctrl.funct3 = funct3D;
        end
    end

    // ALU decoder
    always_comb begin
        ALUControlD = ALUCTRL_W'(c_alu_add);
        case (opD)
            c_op_rtype, c_op_ialu: begin
                case (funct3D)
                    3'b000: begin
                        // sub exists only as R-type; addi ignores instr[30]
                        if ((opD == c_op_rtype) && funct7b5D) begin
                            ALUControlD = ALUCTRL_W'(c_alu_sub);
                        end
                    end
                    3'b010: ALUControlD = ALUCTRL_W'(c_alu_slt);
                    3'b110: ALUControlD = ALUCTRL_W'(c_alu_or);
                    3'b111: ALUControlD = ALUCTRL_W'(c_alu_and);
                    3'b011: begin
                        if (c_ext_alu) ALUControlD = ALUCTRL_W'(c_alu_sltu);
                    end
                    3'b100: begin
                        if (c_ext_alu) ALUControlD = ALUCTRL_W'(c_alu_xor);
                    end
                    3'b001: begin
                        if (c_ext_alu) ALUControlD = ALUCTRL_W'(c_alu_sll);
                    end
                    3'b101: begin
                        if (c_ext_alu) begin
                            ALUControlD = funct7b5D ? ALUCTRL_W'(c_alu_sra)
                                                    : ALUCTRL_W'(c_alu_srl);
                        end
                    end
                    default: ALUControlD = ALUCTRL_W'(c_alu_add);
                endcase
            end
            c_op_branch: begin
                // Unsigned compares need sltu when the ALU provides it
                if (c_ext_alu && (funct3D[2:1] == 2'b11)) begin
                    ALUControlD = ALUCTRL_W'(c_alu_sltu);
                end else begin
                    ALUControlD = ALUCTRL_W'(c_alu_sub);
                end
            end
            default: ALUControlD = ALUCTRL_W'(c_alu_add);
        endcase
        if (w_illegal) begin
            ALUControlD = ALUCTRL_W'(c_alu_add);
        end
    end

    assign ctrlD    = w_ctrl;
    assign IllegalD = w_illegal;

endmodule
`default_nettype wire

// File: rtl/pipe_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_controller
//  Description : Pipelined control unit. Decodes the instruction in Decode and
//                carries its controls through the D->E, E->M and M->W
//                pipeline registers, with stall/flush handling and the
//                branch/jump redirect computed in Execute.
//  Parameters  : ALUCTRL_W (3/4), BRANCH_EXT (0/1)
//  Ports       : clk, reset                      clock, sync active-high reset
//                opD, funct3D, funct7b5D         instruction fields in Decode
//                StallE, FlushE                  hazard controls for E/M/W
//                ZeroE, LtE, LtuE                ALU flags in Execute
//                ImmSrcD, IllegalD               Decode outputs (combinational)
//                ALUSrcE, ALUControlE, PCSrcE,
//                ResultSrcE0                     Execute outputs
//                MemWriteM, RegWriteM            Memory outputs
//                RegWriteW, ResultSrcW           Writeback outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter bit BRANCH_EXT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           opD,
    input  logic [2:0]           funct3D,
    input  logic                 funct7b5D,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 ZeroE,
    input  logic                 LtE,
    input  logic                 LtuE,
    output logic [1:0]           ImmSrcD,
    output logic                 IllegalD,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 PCSrcE,
    output logic                 ResultSrcE0,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic [1:0]           ResultSrcW
);

    ctrl_t                w_ctrl_d;
    logic [ALUCTRL_W-1:0] w_alu_d;

    ctrl_t                r_ctrl_e;
    logic [ALUCTRL_W-1:0] r_alu_e;
    logic                 r_regwrite_m;
    logic                 r_memwrite_m;
    logic [1:0]           r_resultsrc_m;
    logic                 r_regwrite_w;
    logic [1:0]           r_resultsrc_w;

    ctrl_decode #(
        .ALUCTRL_W  (ALUCTRL_W),
        .BRANCH_EXT (BRANCH_EXT)
    ) u_decode (
        .opD         (opD),
        .funct3D     (funct3D),
        .funct7b5D   (funct7b5D),
        .ctrlD       (w_ctrl_d),
        .ALUControlD (w_alu_d),
        .ImmSrcD     (ImmSrcD),
        .IllegalD    (IllegalD)
    );

    // Flush wins over stall for E; M and W advance only when not stalled, so
    // a flush during a stall bubbles E while M and W hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_e      <= c_ctrl_bubble;
            r_alu_e       <= '0;
            r_regwrite_m  <= 1'b0;
            r_memwrite_m  <= 1'b0;
            r_resultsrc_m <= 2'b00;
            r_regwrite_w  <= 1'b0;
            r_resultsrc_w <= 2'b00;
        end else begin
            if (FlushE) begin
                r_ctrl_e <= c_ctrl_bubble;
                r_alu_e  <= '0;
            end else if (!StallE) begin
                r_ctrl_e <= w_ctrl_d;
                r_alu_e  <= w_alu_d;
            end
            if (!StallE) begin
                r_regwrite_m  <= r_ctrl_e.regwrite;
                r_memwrite_m  <= r_ctrl_e.memwrite;
                r_resultsrc_m <= r_ctrl_e.resultsrc;
                r_regwrite_w  <= r_regwrite_m;
                r_resultsrc_w <= r_resultsrc_m;
            end
        end
    end

    assign ALUSrcE     = r_ctrl_e.alusrc;
    assign ALUControlE = r_alu_e;
    assign ResultSrcE0 = r_ctrl_e.resultsrc[0];
    assign PCSrcE      = r_ctrl_e.jump
                       | (r_ctrl_e.branch & branch_taken(r_ctrl_e.funct3, ZeroE, LtE, LtuE));

    assign MemWriteM   = r_memwrite_m;
    assign RegWriteM   = r_regwrite_m;
    assign RegWriteW   = r_regwrite_w;
    assign ResultSrcW  = r_resultsrc_w;

endmodule
`default_nettype wire
